// File: rtl/conv32b_8b.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : conv32b_8b
// Purpose  : Word-to-byte serializer. Buffers up to two 32-bit words in a
//            small FIFO and emits each one as four bytes, most significant
//            byte first, one byte per clk_4f cycle.
// Ports    : clk_4f    - byte-rate clock, rising edge
//            reset_L   - asynchronous active-low reset
//            data_in   - 32-bit input word
//            valid_in  - data_in valid this cycle
//            ready_out - FIFO can take a word this cycle (combinational)
//            data_out  - current byte, 8'h00 when valid_out is low
//            valid_out - data_out holds a valid byte
//            last_out  - marks the final byte (bits 7:0) of each word
// Revision : 1.0 - initial release
// ============================================================================
module conv32b_8b #(
    parameter int DEPTH = 2
) (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        last_out
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Word FIFO storage and bookkeeping
    logic [31:0] mem [0:1];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    // Serializer state
    state_t      state;
    state_t      state_nx;
    logic [1:0]  byte_idx;
    logic [1:0]  byte_idx_nx;
    logic [31:0] shreg;
    logic [31:0] shreg_nx;
    logic [7:0]  data_nx;
    logic        valid_nx;
    logic        last_nx;

    logic        push;
    logic        load;

    // Ready depends only on the registered count, so a pop in the same
    // cycle never frees a slot early.
    assign ready_out = (count != FULL_COUNT);
    assign push      = valid_in && ready_out;
    // A new word is loaded either from idle or straight after the last byte
    // of the current word, which gives gapless back-to-back output.
    assign load      = ((state == IDLE) || (byte_idx == 2'd0)) && (count != 2'd0);

    // FIFO data: no reset needed, entries are only read when count says so
    always_ff @(posedge clk_4f) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (load) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, load})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Serializer state and registered outputs
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            byte_idx  <= 2'd0;
            shreg     <= 32'h0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            state     <= state_nx;
            byte_idx  <= byte_idx_nx;
            shreg     <= shreg_nx;
            data_out  <= data_nx;
            valid_out <= valid_nx;
            last_out  <= last_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        byte_idx_nx = byte_idx;
        shreg_nx    = shreg;
        data_nx     = 8'h00;
        valid_nx    = 1'b0;

        if (load) begin
            // The top byte comes straight from the FIFO head so it appears
            // one cycle after the word is accepted.
            state_nx    = SHIFT;
            byte_idx_nx = 2'd3;
            shreg_nx    = mem[rd_ptr];
            data_nx     = mem[rd_ptr][31:24];
            valid_nx    = 1'b1;
        end else if ((state == SHIFT) && (byte_idx != 2'd0)) begin
            byte_idx_nx = byte_idx - 2'd1;
            valid_nx    = 1'b1;
            case (byte_idx_nx)
                2'd3:    data_nx = shreg[31:24];
                2'd2:    data_nx = shreg[23:16];
                2'd1:    data_nx = shreg[15:8];
                default: data_nx = shreg[7:0];
            endcase
        end else if (state == SHIFT) begin
            // Last byte done and nothing buffered
            state_nx = IDLE;
        end

        last_nx = valid_nx && (byte_idx_nx == 2'd0);
    end

endmodule
`default_nettype wire

// File: tb/tb_conv32b_8b.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_conv32b_8b
// Purpose  : Scoreboard bench for conv32b_8b. The driver predicts, for each
//            accepted word, the exact cycles on which its four bytes appear
//            and queues them; a monitor pops and compares on every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv32b_8b;

    localparam int PERIOD = 10;

    logic        clk_4f;
    logic        reset_L;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        last_out;

    conv32b_8b #(.DEPTH(2)) dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .last_out  (last_out)
    );

    typedef struct {
        int         cyc;
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   starts[$];
    int   next_free;
    int   cyc;
    int   n_cmp;
    int   n_err;

    initial begin
        clk_4f = 1'b0;
        forever #(PERIOD / 2) clk_4f = ~clk_4f;
    end

    // Edge counter: after the k-th rising edge cyc reads k
    initial cyc = 0;
    always @(posedge clk_4f) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Reference model: a word accepted at edge e starts after the later of
    // e+1 and the edge following the previous word's last byte.
    task automatic model_accept(input int e, input logic [31:0] d);
        int start;
        start = (e + 1 > next_free) ? e + 1 : next_free;
        for (int k = 0; k < 4; k++) begin
            exp_t x;
            x.cyc  = start + k;
            x.b    = 8'((d >> (8 * (3 - k))) & 32'hFF);
            x.last = (k == 3);
            exp_q.push_back(x);
        end
        next_free = start + 4;
        starts.push_back(start);
    endtask

    // One cycle of stimulus, set up on the falling edge for the next rising edge
    task automatic drive(input logic v, input logic [31:0] d, output bit acc);
        int e;
        int cnt;
        @(negedge clk_4f);
        e = cyc + 1;
        while (starts.size() > 0 && starts[0] < e) void'(starts.pop_front());
        cnt = starts.size();
        if (reset_L) check("ready_out", {31'b0, ready_out}, {31'b0, cnt != 2});
        valid_in = v;
        data_in  = d;
        acc      = v && (cnt != 2);
        if (acc) model_accept(e, d);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, acc);
    endtask

    task automatic send_word(input logic [31:0] d);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            drive(1'b1, d, acc);
            tries++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_reset_now();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        exp_q.delete();
        starts.delete();
        next_free = 0;
        #1;
        check("rst_valid_out", {31'b0, valid_out}, 32'd0);
        check("rst_data_out", {24'b0, data_out}, 32'd0);
        check("rst_last_out", {31'b0, last_out}, 32'd0);
        check("rst_ready_out", {31'b0, ready_out}, 32'd1);
        @(negedge clk_4f);
        @(negedge clk_4f);
        reset_L = 1'b1;
    endtask

    // Monitor: every cycle out of reset, either a queued byte is due and must
    // be presented, or the outputs must be idle.
    always @(negedge clk_4f) begin
        if (reset_L) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'b0, data_out}, 32'd0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("byte_cycle", cyc, x.cyc);
                    check("data_out", {24'b0, data_out}, {24'b0, x.b});
                    check("last_out", {31'b0, last_out}, {31'b0, x.last});
                end
            end else begin
                check("idle_data_out", {24'b0, data_out}, 32'd0);
                check("idle_last_out", {31'b0, last_out}, 32'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("missing_byte", 32'd0, {24'b0, x.b});
                end
            end
        end
    end

    initial begin
        #(PERIOD * 100000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit acc;
        n_cmp     = 0;
        n_err     = 0;
        next_free = 0;
        valid_in  = 1'b0;
        data_in   = 32'h0;
        reset_L   = 1'b1;
        #2;
        apply_reset_now();

        // Single word, then byte order
        idle(2);
        send_word(32'hFFFFFFFF);
        idle(8);
        send_word(32'h00000003);
        idle(8);

        // Continuous stream with valid held high
        send_word(32'hFFFFFFFF);
        send_word(32'hDDDDDDDD);
        send_word(32'hAABBCCDD);
        // Hold a word against a full FIFO
        send_word(32'h12345678);
        idle(12);

        // Reset between edges after byte 2 of a word
        send_word(32'hCAFEBABE);
        idle(3);
        #2;
        apply_reset_now();
        send_word(32'h01020304);
        idle(8);

        // Idle gaps between words
        for (int i = 0; i < 3; i++) begin
            send_word($urandom);
            idle(5);
        end
        idle(4);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 6), $urandom, acc);
        end
        idle(14);
        check("drain_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
